// File: rtl/wb_regfile_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pipe_pkg
// Description : Shared widths and constants for the MEM/WB pipe and GPR file.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pipe_pkg;

    localparam int          DATA_W_DEF    = 32;
    localparam int          ADDR_W_DEF    = 5;
    localparam int          NREG_DEF      = 32;

    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic        RST_ENABLE    = 1'b1;

    localparam int          STALL_MEM_BIT = 0;
    localparam int          STALL_WB_BIT  = 1;

endpackage
`default_nettype wire

// File: rtl/wb_regfile_pipe_gpr_array.sv
`default_nettype none
// ============================================================================
// Module      : gpr_array
// Description : NREG x DATA_W register storage, one synchronous write port
//               (r0 never written), two asynchronous read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module gpr_array
    import wb_regfile_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= DATA_W'(ZERO_WORD);
            end
        end else if (we == WRITE_ENABLE && waddr != ADDR_W'(NOP_REG_ADDR)) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata1 = r_mem[raddr1];
    assign rdata2 = r_mem[raddr2];

endmodule
`default_nettype wire

// File: rtl/wb_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pipe
// Description : MEM and WB pipeline registers, register-file commit and
//               forwarding read ports for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile_pipe
    import wb_regfile_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREG   = NREG_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic              ex_we_i,
    input  logic [1:0]        stall_i,
    input  logic              flush_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              wb_we_o,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o
);

    logic              r_m_we;
    logic [ADDR_W-1:0] r_m_addr;
    logic [DATA_W-1:0] r_m_data;
    logic              r_w_we;
    logic [ADDR_W-1:0] r_w_addr;
    logic [DATA_W-1:0] r_w_data;

    logic              w_hold_all;
    logic              w_hold_mem;
    logic              w_commit;
    logic [DATA_W-1:0] w_arr_rdata1;
    logic [DATA_W-1:0] w_arr_rdata2;

    // stall_i=2'b10 behaves like 2'b11 because the WB bit alone freezes both stages
    assign w_hold_all = stall_i[STALL_WB_BIT];
    assign w_hold_mem = stall_i[STALL_MEM_BIT];

    assign w_commit = (rst != RST_ENABLE) && r_w_we
                   && (r_w_addr != ADDR_W'(NOP_REG_ADDR))
                   && (flush_i || !w_hold_all);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_m_we   <= WRITE_DISABLE;
            r_m_addr <= '0;
            r_m_data <= '0;
            r_w_we   <= WRITE_DISABLE;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else if (flush_i) begin
            r_m_we   <= WRITE_DISABLE;
            r_m_addr <= '0;
            r_m_data <= '0;
            r_w_we   <= WRITE_DISABLE;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else if (w_hold_all) begin
            r_m_we   <= r_m_we;
            r_w_we   <= r_w_we;
        end else if (w_hold_mem) begin
            r_w_we   <= WRITE_DISABLE;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_m_we   <= ex_we_i;
            r_m_addr <= ex_waddr_i;
            r_m_data <= ex_wdata_i;
            r_w_we   <= r_m_we;
            r_w_addr <= r_m_addr;
            r_w_data <= r_m_data;
        end
    end

    gpr_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREG   (NREG)
    ) u_gpr_array (
        .clk    (clk),
        .rst    (rst),
        .we     (w_commit),
        .waddr  (r_w_addr),
        .wdata  (r_w_data),
        .raddr1 (raddr1_i),
        .raddr2 (raddr2_i),
        .rdata1 (w_arr_rdata1),
        .rdata2 (w_arr_rdata2)
    );

    // Youngest matching producer wins, so a same-cycle commit is seen via W, not the array
    function automatic logic [DATA_W-1:0] fwd_read(
        input logic              re,
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] arr
    );
        logic [DATA_W-1:0] v;
        v = '0;
        if (rst == RST_ENABLE || !re || ra == ADDR_W'(NOP_REG_ADDR)) begin
            v = '0;
        end else if (ex_we_i && ex_waddr_i == ra) begin
            v = ex_wdata_i;
        end else if (r_m_we && r_m_addr == ra) begin
            v = r_m_data;
        end else if (r_w_we && r_w_addr == ra) begin
            v = r_w_data;
        end else begin
            v = arr;
        end
        return v;
    endfunction

    assign rdata1_o   = fwd_read(re1_i, raddr1_i, w_arr_rdata1);
    assign rdata2_o   = fwd_read(re2_i, raddr2_i, w_arr_rdata2);

    assign wb_we_o    = w_commit;
    assign wb_waddr_o = w_commit ? r_w_addr : '0;
    assign wb_wdata_o = w_commit ? r_w_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile_pipe
// Description : Directed and randomized checks of wb_regfile_pipe against a
//               behavioural register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ex_wdata_i;
    logic [4:0]  ex_waddr_i;
    logic        ex_we_i;
    logic [1:0]  stall_i;
    logic        flush_i;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic        wb_we_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_regfile_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .ex_wdata_i (ex_wdata_i),
        .ex_waddr_i (ex_waddr_i),
        .ex_we_i    (ex_we_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .wb_we_o    (wb_we_o),
        .wb_waddr_o (wb_waddr_o),
        .wb_wdata_o (wb_wdata_o)
    );

    // Reference: architectural registers plus an in-flight list, index 0 = MEM, 1 = WB
    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] ref_rf [32];
    wr_t         inflight [2];

    function automatic logic ref_commit();
        return !rst && inflight[1].we && inflight[1].addr != 5'd0 && (flush_i || !stall_i[1]);
    endfunction

    function automatic logic [31:0] ref_read(input logic re, input logic [4:0] ra);
        if (rst || !re || ra == 5'd0) return 32'h0;
        if (ex_we_i && ex_waddr_i == ra) return ex_wdata_i;
        for (int k = 0; k < 2; k++) begin
            if (inflight[k].we && inflight[k].addr == ra) return inflight[k].data;
        end
        return ref_rf[ra];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic c;
        c = ref_commit();
        check("rdata1", rdata1_o, ref_read(re1_i, raddr1_i));
        check("rdata2", rdata2_o, ref_read(re2_i, raddr2_i));
        check("wb_we", {31'd0, wb_we_o}, {31'd0, c});
        check("wb_waddr", {27'd0, wb_waddr_o}, c ? {27'd0, inflight[1].addr} : 32'h0);
        check("wb_wdata", wb_wdata_o, c ? inflight[1].data : 32'h0);
    endtask

    task automatic model_edge();
        wr_t ex;
        ex = '{we: ex_we_i, addr: ex_waddr_i, data: ex_wdata_i};
        if (rst) begin
            for (int i = 0; i < 32; i++) ref_rf[i] = 32'h0;
            inflight[0] = '0;
            inflight[1] = '0;
        end else begin
            if (ref_commit()) ref_rf[inflight[1].addr] = inflight[1].data;
            if (flush_i) begin
                inflight[0] = '0;
                inflight[1] = '0;
            end else if (stall_i[1]) begin
                // everything frozen
            end else if (stall_i[0]) begin
                inflight[1] = '0;
            end else begin
                inflight[1] = inflight[0];
                inflight[0] = ex;
            end
        end
    endtask

    // Drive a cycle's inputs, then compare at mid-cycle against the model
    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [1:0] st, input logic fl,
                         input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        rst = r; ex_we_i = we; ex_waddr_i = wa; ex_wdata_i = wd;
        stall_i = st; flush_i = fl;
        re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
        #4;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic nop_read(input logic [4:0] a);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1, a, 1'b1, a);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_rf[i] = 32'hDEAD_0000 | 32'(i);
        inflight[0] = '0;
        inflight[1] = '0;
        rst = 1'b1; ex_we_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
        stall_i = 0; flush_i = 0; re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
        @(posedge clk);
        model_edge();
        #1;

        // Reset-time outputs and preload of r5
        drive(1'b1, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
        check("rst_rd_during", rdata1_o, 32'h0);
        tick();
        drive(1'b0, 1'b1, 5'd5, 32'h1234, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
        nop_read(5'd5); tick();
        nop_read(5'd5); tick();
        nop_read(5'd5);
        check("preload_r5", rdata1_o, 32'h1234);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1, 5'd5, 1'b1, 5'd5);
        check("rst_r5_high", rdata1_o, 32'h0);
        check("rst_wbwe_high", {31'd0, wb_we_o}, 32'h0);
        tick();
        nop_read(5'd5);
        check("rst_r5_after", rdata1_o, 32'h0);
        check("rst_wbwe_after", {31'd0, wb_we_o}, 32'h0);
        tick();

        // Back-to-back writes to r3
        drive(1'b0, 1'b1, 5'd3, 32'hA, 2'b00, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3);
        check("b2b_ex_a", rdata1_o, 32'hA); tick();
        drive(1'b0, 1'b1, 5'd3, 32'hB, 2'b00, 1'b0, 1'b1, 5'd3, 1'b1, 5'd3);
        check("b2b_ex_b", rdata1_o, 32'hB); tick();
        nop_read(5'd3); check("b2b_mem", rdata1_o, 32'hB); tick();
        nop_read(5'd3); check("b2b_wb", rdata1_o, 32'hB); tick();
        nop_read(5'd3); check("b2b_arr", rdata1_o, 32'hB); tick();

        // r0 guard
        drive(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0);
        check("r0_ex", rdata1_o, 32'h0); tick();
        for (int i = 0; i < 3; i++) begin
            nop_read(5'd0);
            check("r0_rd", rdata2_o, 32'h0);
            check("r0_wbwe", {31'd0, wb_we_o}, 32'h0);
            tick();
        end

        // Stall with W=r7, M=r8
        drive(1'b0, 1'b1, 5'd7, 32'h77, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
        drive(1'b0, 1'b1, 5'd8, 32'h88, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b01, 1'b0, 1'b1, 5'd8, 1'b1, 5'd7);
        check("stall_r7_we", {31'd0, wb_we_o}, 32'h1);
        check("stall_r7_addr", {27'd0, wb_waddr_o}, 32'd7);
        check("stall_r7_data", wb_wdata_o, 32'h77);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b01, 1'b0, 1'b1, 5'd8, 1'b1, 5'd7);
        check("stall_bubble_we", {31'd0, wb_we_o}, 32'h0);
        check("stall_r8_in_m", rdata1_o, 32'h88);
        check("stall_r7_arr", rdata2_o, 32'h77);
        tick();
        nop_read(5'd8); check("release_we", {31'd0, wb_we_o}, 32'h0); tick();
        nop_read(5'd8);
        check("r8_commit_we", {31'd0, wb_we_o}, 32'h1);
        check("r8_commit_data", wb_wdata_o, 32'h88);
        tick();

        // Flush with W=r4, M=r9, EX=r10
        drive(1'b0, 1'b1, 5'd4, 32'h44, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
        drive(1'b0, 1'b1, 5'd9, 32'h99, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
        drive(1'b0, 1'b1, 5'd10, 32'hAA, 2'b11, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        check("flush_r4_we", {31'd0, wb_we_o}, 32'h1);
        check("flush_r4_addr", {27'd0, wb_waddr_o}, 32'd4);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1, 5'd9, 1'b1, 5'd10);
            check("flush_no_commit", {31'd0, wb_we_o}, 32'h0);
            tick();
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0, 1'b1, 5'd9, 1'b1, 5'd10);
        check("flush_r9", rdata1_o, 32'h0);
        check("flush_r10", rdata2_o, 32'h0);
        tick();
        nop_read(5'd4); check("flush_r4_arr", rdata1_o, 32'h44); tick();

        // Dual-port read of r6 while it commits
        drive(1'b0, 1'b1, 5'd6, 32'h66, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0); tick();
        nop_read(5'd1); tick();
        nop_read(5'd6);
        check("dual_we", {31'd0, wb_we_o}, 32'h1);
        check("dual_p1", rdata1_o, 32'h66);
        check("dual_p2", rdata2_o, 32'h66);
        tick();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [1:0] st;
            int sr;
            sr = int'($urandom_range(0, 11));
            st = (sr < 7) ? 2'b00 : (sr < 9) ? 2'b01 : (sr == 9) ? 2'b10 : 2'b11;
            drive(($urandom_range(0, 59) == 0),
                  1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)),
                  $urandom,
                  st,
                  ($urandom_range(0, 13) == 0),
                  1'($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 7)));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
